// File: rtl/msk_pkg.sv
// Shared types and default widths for the MSK modulator.
package msk_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } msk_state_t;

    localparam int unsigned PHASE_W  = 32;
    localparam int unsigned LUT_AW   = 10;
    localparam int unsigned SAMPLE_W = 16;

endpackage

// File: rtl/msk_sin_lut.sv
// Full-wave sine ROM, contents computed at elaboration; combinational read.
module msk_sin_lut
    import msk_pkg::*;
#(
    parameter int unsigned LUT_AW = msk_pkg::LUT_AW,
    parameter int unsigned AMP    = 16384
) (
    input  logic        [LUT_AW-1:0]   addr_i,
    output logic signed [SAMPLE_W-1:0] data_o
);

    localparam int unsigned Depth = 2 ** LUT_AW;
    localparam real         TwoPi = 6.283185307179586;

    logic signed [SAMPLE_W-1:0] rom [Depth];

    for (genvar i = 0; i < Depth; i++) begin : g_rom
        localparam real Val = real'(AMP) * $sin(TwoPi * real'(i) / real'(Depth));
        // Round half away from zero.
        localparam int  Q   = (Val >= 0.0) ? $rtoi(Val + 0.5) : -$rtoi(0.5 - Val);
        assign rom[i] = Q[SAMPLE_W-1:0];
    end

    assign data_o = rom[addr_i];

endmodule

// File: rtl/msk_mod.sv
// Continuous-phase MSK modulator: serial bits in, one signed IF sample per clock out.
module msk_mod
    import msk_pkg::*;
#(
    parameter int unsigned       SPS     = 16,
    parameter int unsigned       PHASE_W = msk_pkg::PHASE_W,
    parameter int unsigned       LUT_AW  = msk_pkg::LUT_AW,
    parameter int unsigned       AMP     = 16384,
    parameter logic [PHASE_W-1:0] FCW_C  = 32'h1000_0000,
    parameter logic [PHASE_W-1:0] FCW_D  = 32'h0400_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bit_valid,
    input  logic                       bit_data,
    output logic                       bit_ready,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       tx_active,
    output logic                       sym_strobe,
    output logic                       underflow
);

    localparam int unsigned       CntW   = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CntW-1:0]   CntMax = CntW'(SPS - 1);
    localparam logic [PHASE_W-1:0] FcwHi = FCW_C + FCW_D;
    localparam logic [PHASE_W-1:0] FcwLo = FCW_C - FCW_D;

    msk_state_t                 state_q, state_d;
    logic [PHASE_W-1:0]         phase_q, phase_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic                       cur_bit_q, cur_bit_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       strobe_q, strobe_d;
    logic                       uf_pend_q, uf_pend_d;
    logic                       underflow_q, underflow_d;

    logic signed [SAMPLE_W-1:0] lut_data;
    logic                       accept;

    msk_sin_lut #(
        .LUT_AW (LUT_AW),
        .AMP    (AMP)
    ) u_lut (
        .addr_i (phase_q[PHASE_W-1 -: LUT_AW]),
        .data_o (lut_data)
    );

    assign bit_ready  = (state_q == IDLE) || (cnt_q == CntMax);
    assign accept     = bit_valid && bit_ready;
    assign tx_active  = (state_q == RUN);
    assign sample_out = sample_q;
    assign sym_strobe = strobe_q;
    assign underflow  = underflow_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        cur_bit_d   = cur_bit_q;
        sample_d    = sample_q;
        strobe_d    = 1'b0;
        uf_pend_d   = 1'b0;
        // Underflow is reported one cycle after leaving RUN, alongside the first zero sample.
        underflow_d = uf_pend_q;

        unique case (state_q)
            IDLE: begin
                phase_d  = '0;
                sample_d = '0;
                if (accept) begin
                    state_d   = RUN;
                    cur_bit_d = bit_data;
                    cnt_d     = '0;
                end
            end
            RUN: begin
                sample_d = lut_data;
                phase_d  = phase_q + (cur_bit_q ? FcwHi : FcwLo);
                cnt_d    = cnt_q + CntW'(1);
                strobe_d = (cnt_q == '0);
                if (cnt_q == CntMax) begin
                    if (accept) begin
                        cur_bit_d = bit_data;
                        cnt_d     = '0;
                    end else begin
                        state_d   = IDLE;
                        phase_d   = '0;
                        cnt_d     = '0;
                        uf_pend_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            cnt_q       <= '0;
            cur_bit_q   <= 1'b0;
            sample_q    <= '0;
            strobe_q    <= 1'b0;
            uf_pend_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            cur_bit_q   <= cur_bit_d;
            sample_q    <= sample_d;
            strobe_q    <= strobe_d;
            uf_pend_q   <= uf_pend_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_msk_mod.sv
// Directed and random-stream bench for msk_mod with default parameters.
module tb_msk_mod;

    localparam int SPS = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               bit_valid;
    logic               bit_data;
    logic               bit_ready;
    logic signed [15:0] sample_out;
    logic               tx_active;
    logic               sym_strobe;
    logic               underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-bit phase increments: FCW_C +/- FCW_D.
    logic [31:0] fcw1 = 32'h1400_0000;
    logic [31:0] fcw0 = 32'h0C00_0000;

    bit          tx_bits[$];
    logic [31:0] exp_bnd[$];

    msk_mod dut (
        .clk        (clk),
        .reset      (reset),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .bit_ready  (bit_ready),
        .sample_out (sample_out),
        .tx_active  (tx_active),
        .sym_strobe (sym_strobe),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic signed [15:0] model_lut(input logic [31:0] p);
        int  idx;
        real v;
        int  r;
        idx = int'(p[31:22]);
        v   = 16384.0 * $sin(2.0 * 3.141592653589793 * real'(idx) / 1024.0);
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(0.5 - v);
        return r[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (sample_out !== 16'sd0) begin
            n_fail++; $display("FAIL reset_sample: got %0d want 0", sample_out);
        end
        n_checks++;
        if ({bit_ready, tx_active, sym_strobe, underflow} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 1000",
                               {bit_ready, tx_active, sym_strobe, underflow});
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 100; c++) begin
            tick();
            n_checks++;
            if ({sample_out, bit_ready, tx_active, sym_strobe, underflow} !==
                {16'sd0, 4'b1000}) begin
                n_fail++;
                $display("FAIL idle cyc %0d: sample=%0d flags=%b want 0/1000", c, sample_out,
                         {bit_ready, tx_active, sym_strobe, underflow});
            end
        end
    endtask

    // Sends tx_bits with valid held, checking every output cycle against the phase model.
    task automatic run_stream(input string tag);
        int          n;
        logic [31:0] p;
        logic        last;
        logic        exp_ready;
        n = tx_bits.size();
        p = 32'h0;
        bit_valid = 1'b1;
        bit_data  = tx_bits[0];
        tick();
        n_checks++;
        if ({sample_out, bit_ready, tx_active, sym_strobe} !== {16'sd0, 3'b010}) begin
            n_fail++;
            $display("FAIL %s accept: sample=%0d rdy/act/stb=%b want 0/010", tag, sample_out,
                     {bit_ready, tx_active, sym_strobe});
        end
        for (int s = 0; s < n; s++) begin
            for (int j = 0; j < SPS; j++) begin
                tick();
                last      = (s == n - 1) && (j == SPS - 1);
                exp_ready = last ? 1'b1 : (j == SPS - 2);
                n_checks++;
                if (sample_out !== model_lut(p)) begin
                    n_fail++;
                    $display("FAIL %s sample sym %0d idx %0d: got %0d want %0d", tag, s, j,
                             sample_out, model_lut(p));
                end
                n_checks++;
                if ({bit_ready, tx_active, sym_strobe, underflow} !==
                    {exp_ready, !last, (j == 0), 1'b0}) begin
                    n_fail++;
                    $display("FAIL %s flags sym %0d idx %0d: got %b want %b", tag, s, j,
                             {bit_ready, tx_active, sym_strobe, underflow},
                             {exp_ready, !last, (j == 0), 1'b0});
                end
                p = p + (tx_bits[s] ? fcw1 : fcw0);
                if (j == SPS - 1) begin
                    if (s < n - 1 && s < exp_bnd.size()) begin
                        n_checks++;
                        if (dut.phase_q !== exp_bnd[s]) begin
                            n_fail++;
                            $display("FAIL %s boundary phase %0d: got %h want %h", tag, s,
                                     dut.phase_q, exp_bnd[s]);
                        end
                    end else if (s == n - 1) begin
                        n_checks++;
                        if (dut.phase_q !== 32'h0) begin
                            n_fail++;
                            $display("FAIL %s end phase: got %h want 0", tag, dut.phase_q);
                        end
                    end
                end
                if (j == SPS - 2) begin
                    if (s < n - 1) bit_data = tx_bits[s + 1];
                    else           bit_valid = 1'b0;
                end
            end
        end
        tick();
        n_checks++;
        if ({sample_out, bit_ready, tx_active, sym_strobe, underflow} !==
            {16'sd0, 4'b1001}) begin
            n_fail++;
            $display("FAIL %s underflow: sample=%0d flags=%b want 0/1001", tag, sample_out,
                     {bit_ready, tx_active, sym_strobe, underflow});
        end
        tick();
        n_checks++;
        if ({sample_out, underflow} !== {16'sd0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s post_underflow: sample=%0d uf=%b want 0/0", tag, sample_out,
                     underflow);
        end
    endtask

    task automatic test_single_bit();
        tx_bits = '{1'b1};
        exp_bnd = '{};
        run_stream("single");
    endtask

    task automatic test_back_to_back();
        tx_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_bnd = '{32'h4000_0000, 32'h0000_0000, 32'h4000_0000};
        run_stream("b2b");
    endtask

    task automatic test_bubble();
        tx_bits = '{1'b1, 1'b0};
        exp_bnd = '{};
        run_stream("bubble_a");
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({sample_out, tx_active, underflow} !== {16'sd0, 2'b00}) begin
                n_fail++;
                $display("FAIL bubble_gap cyc %0d: sample=%0d act/uf=%b want 0/00", c,
                         sample_out, {tx_active, underflow});
            end
        end
        tx_bits = '{1'b0, 1'b1};
        run_stream("bubble_b");
    endtask

    task automatic test_random();
        tx_bits.delete();
        exp_bnd = '{};
        for (int i = 0; i < 1000; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
        run_stream("random");
    endtask

    task automatic test_reset_mid();
        bit_valid = 1'b1;
        bit_data  = 1'b1;
        tick();
        bit_valid = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        // Sample 6 of a bit-1 symbol: phase 0x7800_0000.
        n_checks++;
        if (sample_out !== model_lut(32'h7800_0000) || !tx_active) begin
            n_fail++;
            $display("FAIL midrst_pre: sample=%0d act=%b want %0d/1", sample_out, tx_active,
                     model_lut(32'h7800_0000));
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({sample_out, bit_ready, tx_active, sym_strobe, underflow} !==
            {16'sd0, 4'b1000} || dut.phase_q !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_state: sample=%0d flags=%b phase=%h want 0/1000/0",
                     sample_out, {bit_ready, tx_active, sym_strobe, underflow}, dut.phase_q);
        end
        bit_valid = 1'b1;
        tick();
        n_checks++;
        if (tx_active !== 1'b0) begin
            n_fail++; $display("FAIL rst_priority: tx_active=%b want 0", tx_active);
        end
        reset     = 1'b0;
        bit_valid = 1'b0;
        tick();
        n_checks++;
        if ({sample_out, tx_active, underflow} !== {16'sd0, 2'b00}) begin
            n_fail++;
            $display("FAIL midrst_after: sample=%0d act/uf=%b want 0/00", sample_out,
                     {tx_active, underflow});
        end
        tx_bits = '{1'b0, 1'b1};
        exp_bnd = '{32'hC000_0000};
        run_stream("after_rst");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_bit();
        test_back_to_back();
        test_bubble();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/msk_mod.md
# msk_mod

MSK modulator feeding the AWGN noise stage in the MSK modem datapath.
- Accepts a serial bit stream over a valid/ready handshake.
- Produces one continuous-phase real 16-bit signed IF sample per clock on `sample_out`; the AWGN stage consumes it directly as `signal_in`.
- Bit 1 raises the instantaneous frequency by Rb/4 and bit 0 lowers it by Rb/4. The net phase change per symbol is ±π/2.

## Interface
- `SPS`, 16: samples per symbol (≥2).
- `PHASE_W`, 32: phase accumulator width.
- `LUT_AW`, 10: sine table address width (2^LUT_AW entries, full wave).
- `AMP`, 16384: peak sample amplitude (1..32767).
- `FCW_C`, 32'h1000_0000: carrier frequency control word (fc = fs·FCW_C/2^PHASE_W).
- `FCW_D`, 32'h0400_0000: deviation word; equals 2^PHASE_W/(4·SPS) for true MSK.
- `clk` in 1: sample clock, one sample per cycle.
- `reset` in 1: synchronous, active-high.
- `bit_valid` in 1: `bit_data` is valid.
- `bit_data` in 1: symbol bit.
- `bit_ready` out 1: the modulator accepts a bit this cycle.
- `sample_out` out 16 signed: modulated sample.
- `tx_active` out 1: the modulator is in the RUN state.
- `sym_strobe` out 1: one-cycle pulse aligned with the first sample of each symbol on `sample_out`.
- `underflow` out 1: one-cycle pulse when a burst ends because no bit was offered at a symbol boundary.

## Operation
- States: IDLE, RUN.
- Registers: `state`, `phase_acc[PHASE_W]`, `cnt` (0..SPS-1), `cur_bit`, `sample_out`, `sym_strobe`, `underflow`.
- `bit_ready` is combinational: 1 in IDLE; in RUN, 1 only when `cnt==SPS-1`. It never depends on `bit_valid`.
- IDLE behaviour:
  - `phase_acc` is held at 0 and `sample_out` is registered to 0.
  - On accept (`bit_valid & bit_ready`): go to RUN, load `cur_bit`, set `cnt=0`.
- RUN, every cycle:
  - `sample_out <= LUT[phase_acc[PHASE_W-1 -: LUT_AW]]`.
  - `phase_acc <= phase_acc + (cur_bit ? FCW_C+FCW_D : FCW_C-FCW_D)`, with the sum wrapping modulo 2^PHASE_W.
  - `cnt` increments.
- RUN, at `cnt==SPS-1`:
  - If a bit is accepted: load `cur_bit`, set `cnt=0`, stay in RUN. Phase is NOT reset, which keeps the phase continuous.
  - Otherwise: go to IDLE, set `phase_acc<=0`, and assert `underflow` on the next cycle.
- `sym_strobe` is registered high on the edge that outputs the sample taken at `cnt==0`.
- LUT contents: entry i = round(AMP·sin(2π·i/2^LUT_AW)), computed at elaboration. Index is formed by truncating the phase; no dithering.
- Reset values: `state`=IDLE, `phase_acc`=0, `cnt`=0, `cur_bit`=0, `sample_out`=0, `sym_strobe`=0, `underflow`=0. Consequently `bit_ready`=1 and `tx_active`=0 out of reset.
- Reset asserted mid-burst: all registers return to their reset values on that edge. The partial symbol is discarded with no `underflow` pulse.
- Reset has priority over a simultaneous accept.

## Timing
- Accept edge E0 → first sample (sin 0 = 0) and `sym_strobe` appear after E1. Latency from accept to first sample is 1 cycle.
- Sample n of a burst is LUT[top bits of P_n], where P_0=0 and P_{n+1}=P_n+FCW(bit of symbol ⌊n/SPS⌋).
- With uninterrupted valid bits, consecutive symbols output gap-free: SPS samples per symbol and `bit_ready` high exactly 1 cycle in every SPS.
- On underflow, the last sample of the final symbol appears on the edge that leaves RUN. `sample_out`=0 and `underflow`=1 follow on the next cycle.
- Throughput: at most 1 bit per SPS cycles.

## Structure
- Package `msk_pkg`:
  - `typedef enum logic {IDLE, RUN} msk_state_t`;
  - default constants `PHASE_W`, `LUT_AW`, `SAMPLE_W=16`.
- Sub-module `msk_sin_lut` (params `LUT_AW`, `AMP`): combinational read of an elaboration-initialised ROM. The output register lives in `msk_mod`.

## Test plan
- Reset, then idle with `bit_valid`=0 → `sample_out`=0, `bit_ready`=1, `tx_active`=0, no strobes, for 100 cycles.
- Single bit 1 (defaults), no further valid:
  - `tx_active` high 16 cycles; 16 samples output, first = 0;
  - accumulated phase at the boundary = 32'h4000_0000;
  - then `underflow` pulses once and `sample_out` returns to 0.
- Continuous bits 1,0,1,1 with valid held:
  - `bit_ready` high at `cnt`=15 only;
  - phase at symbol boundaries = 32'h4000_0000, 32'h0000_0000, 32'h4000_0000, 32'h8000_0000;
  - `sym_strobe` every 16 cycles; no gaps.
- Every `sample_out` compared against a real-valued model of round(AMP·sin(2π·trunc(P_n))) → exact match over a 1000-bit random stream.
- Bubble: valid dropped across one boundary then reasserted 5 cycles later → `underflow` pulse, IDLE, and the new burst restarts with phase 0 and first sample 0.
- Reset asserted at `cnt`=7 of a symbol → next cycle all outputs equal reset values, no `underflow`; next accepted bit starts cleanly.
